// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: FIFO read-port and valid/ready output-stream signals of the read-side adapter.
interface fifo_rd_stream_if #(parameter int WIDTH = 16);
    logic             fifo_empty;
    logic [WIDTH-1:0] rd_data;
    logic             rd_en;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic [1:0]       buf_cnt;
    modport master (
        input  fifo_empty, rd_data, m_ready,
        output rd_en, m_valid, m_data, m_last, buf_cnt
    );
    modport slave (
        output fifo_empty, rd_data, m_ready,
        input  rd_en, m_valid, m_data, m_last, buf_cnt
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: pops the async FIFO into a 3-entry queue and presents it as a framed valid/ready stream.
module fifo_rd_stream #(
    parameter int WIDTH   = 16,
    parameter int PKT_LEN = 8
) (
    input  logic             rd_clk,
    input  logic             rst_n,
    fifo_rd_stream_if.master bus
);
    localparam int            BW   = PKT_LEN > 1 ? $clog2(PKT_LEN) : 1;
    localparam logic [BW-1:0] LAST = BW'(PKT_LEN - 1);
    logic [WIDTH-1:0] r_mem [3];
    logic [1:0]       r_head;
    logic [1:0]       r_tail;
    logic [1:0]       r_cnt;
    logic [1:0]       r_hold;
    logic             r_inflight;
    logic [BW-1:0]    r_beat;
    logic             w_credit;
    logic             w_pop;
    logic             w_deq;
    // Credit counts the word still in flight so the queue can never overflow; m_ready never reaches rd_en.
    always_comb begin
        w_credit = ({1'b0, r_cnt} + {2'b00, r_inflight}) < 3'd3;
        w_pop    = ~bus.fifo_empty & (r_hold == 2'd0) & w_credit;
        w_deq    = (r_cnt != 2'd0) & bus.m_ready;
    end
    assign bus.rd_en   = w_pop;
    assign bus.m_valid = r_cnt != 2'd0;
    assign bus.m_data  = r_mem[r_head];
    assign bus.m_last  = (r_cnt != 2'd0) & (r_beat == LAST);
    assign bus.buf_cnt = r_cnt;
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem      <= '{default: '0};
            r_head     <= 2'd0;
            r_tail     <= 2'd0;
            r_cnt      <= 2'd0;
            r_hold     <= 2'd2;
            r_inflight <= 1'b0;
            r_beat     <= '0;
        end else begin
            r_inflight <= w_pop;
            if (r_hold != 2'd0) r_hold <= r_hold - 2'd1;
            if (r_inflight) begin
                r_mem[r_tail] <= bus.rd_data;
                r_tail        <= r_tail == 2'd2 ? 2'd0 : r_tail + 2'd1;
            end
            if (w_deq) begin
                r_head <= r_head == 2'd2 ? 2'd0 : r_head + 2'd1;
                r_beat <= r_beat == LAST ? '0 : r_beat + BW'(1);
            end
            r_cnt <= r_cnt + 2'(r_inflight) - 2'(w_deq);
        end
    end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: queue-based FIFO model and scoreboard around the read-side stream adapter.
module tb_fifo_rd_stream;
    localparam int W  = 16;
    localparam int PL = 8;
    typedef struct {
        logic [W-1:0] d;
        logic         l;
        int           c;
    } beat_t;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;
    fifo_rd_stream_if #(.WIDTH(W)) bus ();
    fifo_rd_stream_if #(.WIDTH(W)) bus1 ();
    fifo_rd_stream #(.WIDTH(W), .PKT_LEN(PL)) dut  (.rd_clk(clk), .rst_n(rst_n), .bus(bus.master));
    fifo_rd_stream #(.WIDTH(W), .PKT_LEN(1))  dut1 (.rd_clk(clk), .rst_n(rst_n), .bus(bus1.master));
    logic [W-1:0] fifo_q[$];
    logic [W-1:0] src[$];
    beat_t        outq[$];
    bit           wr_rand    = 1'b0;
    bit           clr_on_rst = 1'b1;
    bit           infl       = 1'b0;
    int           pops       = 0;
    int           cyc        = 0;
    int           t_fill     = -1;
    int           left1      = 0;
    logic [W-1:0] nxt1       = '0;
    int           cmp        = 0;
    int           errs       = 0;
    // FIFO model: registered empty flag, data returned the edge after a pop; also logs accepted beats
    always @(posedge clk) begin
        logic [W-1:0] t;
        beat_t        b;
        cyc++;
        if (rst_n && bus.m_valid && bus.m_ready) begin
            b.d = bus.m_data; b.l = bus.m_last; b.c = cyc;
            outq.push_back(b);
        end
        infl <= rst_n && bus.rd_en && !bus.fifo_empty;
        if (!rst_n && clr_on_rst) fifo_q.delete();
        else begin
            if (rst_n && bus.rd_en && !bus.fifo_empty) begin
                t = fifo_q.pop_front();
                bus.rd_data <= t;
                pops++;
            end
            if (src.size() > 0 && (!wr_rand || $urandom_range(1, 0) == 1)) begin
                if (fifo_q.size() == 0 && t_fill < 0) t_fill = cyc;
                fifo_q.push_back(src.pop_front());
            end
        end
        bus.fifo_empty <= fifo_q.size() == 0;
    end
    always @(posedge clk) begin
        if (rst_n && bus1.rd_en && !bus1.fifo_empty) begin
            bus1.rd_data <= nxt1;
            nxt1++;
            left1--;
        end
        bus1.fifo_empty <= left1 <= 0;
    end
    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        src.delete();
        repeat (2) @(negedge clk);
        outq.delete();
        pops  = 0;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask
    task automatic test_reset;
        logic [W-1:0] exp[3] = '{16'h0b01, 16'h0b02, 16'h0b03};
        clr_on_rst = 1'b0;
        bus.m_ready = 1'b1;
        foreach (exp[i]) src.push_back(exp[i]);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (4) begin
            @(negedge clk);
            cmp++;
            if ({bus.rd_en, bus.m_valid, bus.m_last, bus.buf_cnt, bus.m_data} !== '0) begin
                errs++;
                $display("FAIL reset_outputs: rd_en=%b valid=%b last=%b cnt=%0d data=%h, all must be 0",
                         bus.rd_en, bus.m_valid, bus.m_last, bus.buf_cnt, bus.m_data);
            end
        end
        outq.delete();
        pops  = 0;
        rst_n = 1'b1;
        #1 cmp++;
        if (bus.fifo_empty !== 1'b0 || bus.rd_en !== 1'b0) begin
            errs++;
            $display("FAIL hold_release: rd_en=%b empty=%b, need rd_en=0 empty=0", bus.rd_en, bus.fifo_empty);
        end
        @(negedge clk);
        cmp++;
        if (bus.rd_en !== 1'b0) begin errs++; $display("FAIL hold_edge1: rd_en=%b need 0", bus.rd_en); end
        @(negedge clk);
        cmp++;
        if (bus.rd_en !== 1'b1) begin errs++; $display("FAIL hold_edge2: rd_en=%b need 1", bus.rd_en); end
        for (int i = 0; i < 30 && outq.size() < 3; i++) @(negedge clk);
        cmp++;
        if (outq.size() != 3) begin errs++; $display("FAIL reset_beats: got %0d beats need 3", outq.size()); end
        for (int i = 0; i < 3 && i < outq.size(); i++) begin
            cmp++;
            if (outq[i].d !== exp[i]) begin
                errs++; $display("FAIL reset_data[%0d]: got %h need %h", i, outq[i].d, exp[i]);
            end
        end
        clr_on_rst = 1'b1;
    endtask
    task automatic test_streaming;
        do_reset();
        bus.m_ready = 1'b1;
        t_fill = -1;
        for (int i = 1; i <= 16; i++) src.push_back(W'(i));
        for (int i = 0; i < 100 && outq.size() < 16; i++) @(negedge clk);
        cmp++;
        if (outq.size() != 16) begin errs++; $display("FAIL stream_count: got %0d need 16", outq.size()); end
        else begin
            cmp++;
            if (outq[0].c != t_fill + 3) begin
                errs++; $display("FAIL stream_latency: first beat edge %0d need %0d", outq[0].c, t_fill + 3);
            end
            for (int i = 0; i < 16; i++) begin
                cmp++;
                if (outq[i].d !== W'(i + 1) || outq[i].l !== (i % PL == PL - 1) || outq[i].c != outq[0].c + i) begin
                    errs++;
                    $display("FAIL stream_beat[%0d]: data=%h last=%b edge=%0d need data=%h last=%b edge=%0d",
                             i, outq[i].d, outq[i].l, outq[i].c, i + 1, i % PL == PL - 1, outq[0].c + i);
                end
            end
        end
        @(negedge clk);
        cmp++;
        if (bus.m_valid !== 1'b0) begin errs++; $display("FAIL stream_drain: valid=%b need 0", bus.m_valid); end
    endtask
    task automatic test_backpressure;
        int base = outq.size();
        int p0   = pops;
        bus.m_ready = 1'b0;
        for (int i = 0; i < 10; i++) src.push_back(W'(16'h0100 + i));
        repeat (20) begin
            @(negedge clk);
            if (bus.m_valid) begin
                cmp++;
                if (bus.m_data !== 16'h0100) begin
                    errs++; $display("FAIL bp_hold_data: got %h need 0100", bus.m_data);
                end
            end
            if (int'(bus.buf_cnt) + int'(infl) == 3) begin
                cmp++;
                if (bus.rd_en !== 1'b0) begin errs++; $display("FAIL bp_credit: rd_en=%b need 0", bus.rd_en); end
            end
        end
        cmp++;
        if (pops - p0 != 3 || bus.buf_cnt !== 2'd3 || bus.m_valid !== 1'b1) begin
            errs++;
            $display("FAIL bp_full: pops=%0d cnt=%0d valid=%b need pops=3 cnt=3 valid=1",
                     pops - p0, bus.buf_cnt, bus.m_valid);
        end
        bus.m_ready = 1'b1;
        @(negedge clk);
        cmp++;
        if (bus.rd_en !== 1'b1) begin errs++; $display("FAIL bp_refill: rd_en=%b need 1", bus.rd_en); end
        for (int i = 0; i < 100 && outq.size() < base + 10; i++) @(negedge clk);
        cmp++;
        if (outq.size() != base + 10) begin
            errs++; $display("FAIL bp_count: got %0d beats need 10", outq.size() - base);
        end
        for (int i = base; i < outq.size(); i++) begin
            cmp++;
            if (outq[i].d !== W'(16'h0100 + i - base) || outq[i].l !== (i % PL == PL - 1)) begin
                errs++;
                $display("FAIL bp_beat[%0d]: data=%h last=%b need data=%h last=%b",
                         i - base, outq[i].d, outq[i].l, 16'h0100 + i - base, i % PL == PL - 1);
            end
        end
        @(negedge clk);
        cmp++;
        if (bus.m_valid !== 1'b0 || bus.buf_cnt !== 2'd0) begin
            errs++; $display("FAIL bp_drain: valid=%b cnt=%0d need 0/0", bus.m_valid, bus.buf_cnt);
        end
    endtask
    task automatic test_random;
        logic [W-1:0] exp[$];
        int           base = outq.size();
        logic         pv = 1'b0, pr = 1'b0, pl = 1'b0;
        logic [W-1:0] pd = '0;
        wr_rand = 1'b1;
        for (int i = 0; i < 200; i++) begin
            exp.push_back(W'($urandom));
            src.push_back(exp[i]);
        end
        for (int i = 0; i < 4000 && outq.size() < base + 200; i++) begin
            @(negedge clk);
            if (pv && !pr) begin
                cmp++;
                if ({bus.m_valid, bus.m_data, bus.m_last} !== {1'b1, pd, pl}) begin
                    errs++;
                    $display("FAIL rnd_stable: valid=%b data=%h last=%b need 1/%h/%b",
                             bus.m_valid, bus.m_data, bus.m_last, pd, pl);
                end
            end
            cmp++;
            if (int'(bus.buf_cnt) != pops - int'(infl) - outq.size() || int'(bus.buf_cnt) + int'(infl) > 3) begin
                errs++;
                $display("FAIL rnd_occupancy: cnt=%0d inflight=%b need cnt=%0d and sum<=3",
                         bus.buf_cnt, infl, pops - int'(infl) - outq.size());
            end
            bus.m_ready = $urandom_range(1, 0) == 1;
            pv = bus.m_valid; pr = bus.m_ready; pd = bus.m_data; pl = bus.m_last;
        end
        bus.m_ready = 1'b1;
        wr_rand = 1'b0;
        cmp++;
        if (outq.size() != base + 200) begin
            errs++; $display("FAIL rnd_count: got %0d beats need 200", outq.size() - base);
        end
        for (int i = base; i < outq.size(); i++) begin
            cmp++;
            if (outq[i].d !== exp[i - base] || outq[i].l !== (i % PL == PL - 1)) begin
                errs++;
                $display("FAIL rnd_beat[%0d]: data=%h last=%b need data=%h last=%b",
                         i - base, outq[i].d, outq[i].l, exp[i - base], i % PL == PL - 1);
            end
        end
    endtask
    task automatic test_pkt1;
        logic [W-1:0] got[$];
        bus1.m_ready = 1'b1;
        @(negedge clk);
        nxt1  = W'(1);
        left1 = 5;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            cmp++;
            if (bus1.m_last !== bus1.m_valid) begin
                errs++; $display("FAIL pkt1_last: last=%b need valid=%b", bus1.m_last, bus1.m_valid);
            end
            if (bus1.m_valid) got.push_back(bus1.m_data);
        end
        cmp++;
        if (got.size() != 5) begin errs++; $display("FAIL pkt1_count: got %0d need 5", got.size()); end
        foreach (got[i]) begin
            cmp++;
            if (got[i] !== W'(i + 1)) begin errs++; $display("FAIL pkt1_data[%0d]: got %h need %h", i, got[i], i + 1); end
        end
    endtask
    task automatic test_midreset;
        int n_last = 0;
        bit hit    = 1'b0;
        bus.m_ready = 1'b0;
        for (int i = 0; i < 6; i++) src.push_back(W'(16'h0200 + i));
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            hit = bus.buf_cnt == 2'd2 && infl;
        end
        cmp++;
        if (!hit) begin errs++; $display("FAIL mid_setup: cnt=%0d inflight=%b need 2/1", bus.buf_cnt, infl); end
        rst_n = 1'b0;
        #1 cmp++;
        if ({bus.rd_en, bus.m_valid, bus.m_last, bus.buf_cnt, bus.m_data} !== '0) begin
            errs++;
            $display("FAIL mid_async: rd_en=%b valid=%b last=%b cnt=%0d data=%h, all must be 0",
                     bus.rd_en, bus.m_valid, bus.m_last, bus.buf_cnt, bus.m_data);
        end
        src.delete();
        repeat (2) @(negedge clk);
        outq.delete();
        pops  = 0;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 10; i++) src.push_back(W'(16'h0300 + i));
        for (int i = 0; i < 100 && outq.size() < 10; i++) @(negedge clk);
        cmp++;
        if (outq.size() != 10) begin errs++; $display("FAIL mid_count: got %0d need 10", outq.size()); end
        foreach (outq[i]) begin
            n_last += int'(outq[i].l);
            cmp++;
            if (outq[i].d !== W'(16'h0300 + i) || outq[i].l !== (i == PL - 1)) begin
                errs++;
                $display("FAIL mid_beat[%0d]: data=%h last=%b need data=%h last=%b",
                         i, outq[i].d, outq[i].l, 16'h0300 + i, i == PL - 1);
            end
        end
        cmp++;
        if (n_last != 1) begin errs++; $display("FAIL mid_last_count: got %0d need 1", n_last); end
    endtask
    initial begin
        bus.m_ready  = 1'b1;
        bus1.m_ready = 1'b1;
        test_reset();
        test_streaming();
        test_backpressure();
        test_random();
        test_pkt1();
        test_midreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
